shop_cmd_packer: RTL and testbench
==================================

Name: shop_cmd_packer

Overview:
- Upstream input stage of the shop command FSM.
- Takes a byte-serial ASCII stream (one character per strobe) and packs each newline-terminated token into a WORD_BITS-wide word.
- Each completed word is presented on o_a with a one-cycle o_rdy strobe; this drives the FSM's i_a / i_rdy directly.
- Packing is right-justified, so a packed word compares bit-exactly against a Verilog string literal (e.g. "Adm" = 24'h41646D, "Bu" = 24'h004275).

Parameters:
- WORD_CHARS, 3, maximum characters per token.
- WORD_BITS, 8*WORD_CHARS (24), output word width; must equal the FSM's I_A_NUM_BITS.
- TERM_CHAR, 8'h0A, token terminator (LF).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_c_vld  in  1  input character valid, sampled each rising edge; no backpressure.
- i_c  in  8  ASCII character.
- o_rdy  out  1  one-cycle strobe: o_a holds a completed token.
- o_a  out  WORD_BITS  packed token; held stable until the next o_rdy.
- o_err  out  1  one-cycle strobe: token dropped (overflow or illegal character).
- o_len  out  2 (clog2(WORD_CHARS+1))  character count of the token on o_a.

Behaviour:
- Reset (async, while i_reset=1):
  - state=FILL, cnt=0, shift register=0.
  - o_rdy=0, o_err=0, o_a=0, o_len=0.
  - Asserting reset mid-token discards the partial token; no strobe is produced.
- Character classes, evaluated only when i_c_vld=1:
  - TERM: i_c==TERM_CHAR.
  - CR: 8'h0D, always ignored (no state change).
  - PRINT: 8'h20..8'h7E.
  - Anything else is ILLEGAL.
- State FILL:
  - PRINT with cnt<WORD_CHARS: shift register <= {sr[WORD_BITS-9:0], i_c}; cnt++.
  - PRINT with cnt==WORD_CHARS: overflow. Go to DROP, pulse o_err next cycle.
  - ILLEGAL: go to DROP, pulse o_err next cycle.
  - TERM with cnt>0: o_a<=sr, o_len<=cnt, o_rdy<=1 for exactly one cycle; then sr<=0, cnt<=0, stay in FILL.
  - TERM with cnt==0: empty token, ignored. No strobe, no error.
- State DROP:
  - Discard every character until TERM.
  - On TERM: sr<=0, cnt<=0, return to FILL. No o_rdy, no second o_err.
- Latency: TERM accepted at edge N gives o_rdy=1 and o_a valid during cycle N+1. o_err follows the same timing.
- Back-to-back: a character may be accepted in the cycle o_rdy is high.
  - A TERM on every other cycle yields one strobe per token.
  - The packer never stalls.
- Strobe rules: o_rdy and o_err are never high in the same cycle. o_a and o_len change only on o_rdy.
- Width rule: the shift register is truncating. Characters older than WORD_CHARS cannot survive, because overflow forces DROP first.

Optional Feature:
- Macro: SHOP_CMD_PACKER_BACKSPACE_EN.
- Defined:
  - 8'h08 (BS) and 8'h7F (DEL) in FILL with cnt>0: sr <= sr>>8, cnt--.
  - With cnt==0: ignored.
  - In DROP: ignored.
  - These codes are not ILLEGAL.
- Not defined: 8'h08 and 8'h7F are ILLEGAL (DROP + o_err).

Test Plan:
- Reset then "Adm\n" -> one cycle after LF: o_rdy=1, o_a=24'h41646D, o_len=3; o_rdy low the following cycle.
- "Bu\r\n" -> o_a=24'h004275, o_len=2; CR has no effect.
- "Logo\n" -> o_err=1 one cycle after the 4th char; no o_rdy; a following "Buy\n" gives o_a=24'h427579.
- "\n\n" and "A\x01B\n" -> "\n\n": no strobes. "A\x01B\n": o_err after 0x01, no o_rdy; next "X\n" gives o_a=24'h000058.
- i_reset pulsed after "Ad" with no LF, then "\n" -> no o_rdy, o_a stays 0; then "Adm\n" packs normally.
- With SHOP_CMD_PACKER_BACKSPACE_EN defined: "Adx\x08m\n" -> o_a=24'h41646D. Without the macro, the same stream -> o_err, no o_rdy.

Source files
------------

// File: rtl/shop_cmd_packer.sv
// Packs a byte-serial, LF-terminated ASCII token stream into right-justified words.
// Optional macro SHOP_CMD_PACKER_BACKSPACE_EN makes BS/DEL erase the last character.
module shop_cmd_packer #(
   parameter int unsigned WORD_CHARS = 3,
   parameter int unsigned WORD_BITS  = 8 * WORD_CHARS,
   parameter logic [7:0]  TERM_CHAR  = 8'h0A,
   localparam int unsigned LEN_BITS  = $clog2(WORD_CHARS + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_c_vld,
   input  logic [7:0]           i_c,
   output logic                 o_rdy,
   output logic [WORD_BITS-1:0] o_a,
   output logic                 o_err,
   output logic [LEN_BITS-1:0]  o_len
);

   localparam logic [LEN_BITS-1:0] MAX_CNT = LEN_BITS'(WORD_CHARS);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_DROP = 1'b1
   } state_t;

   state_t               state;
   logic [WORD_BITS-1:0] sr;
   logic [LEN_BITS-1:0]  cnt;

   logic is_term;
   logic is_cr;
   logic is_print;
   logic is_bs;

   // Character classification; the terminator wins over every other class.
   always_comb begin
      is_term  = (i_c == TERM_CHAR);
      is_cr    = (i_c == 8'h0D);
      is_print = (i_c >= 8'h20) && (i_c <= 8'h7E);
`ifdef SHOP_CMD_PACKER_BACKSPACE_EN
      is_bs    = (i_c == 8'h08) || (i_c == 8'h7F);
`else
      is_bs    = 1'b0;
`endif
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= ST_FILL;
         sr    <= '0;
         cnt   <= '0;
         o_rdy <= 1'b0;
         o_err <= 1'b0;
         o_a   <= '0;
         o_len <= '0;
      end else begin
         o_rdy <= 1'b0;
         o_err <= 1'b0;
         if (i_c_vld) begin
            case (state)
               ST_FILL: begin
                  if (is_term) begin
                     if (cnt != '0) begin
                        o_a   <= sr;
                        o_len <= cnt;
                        o_rdy <= 1'b1;
                     end
                     sr  <= '0;
                     cnt <= '0;
                  end else if (!is_cr) begin
                     if (is_print) begin
                        if (cnt == MAX_CNT) begin
                           state <= ST_DROP;
                           o_err <= 1'b1;
                        end else begin
                           sr  <= (sr << 8) | WORD_BITS'(i_c);
                           cnt <= cnt + LEN_BITS'(1);
                        end
                     end else if (is_bs) begin
                        if (cnt != '0) begin
                           sr  <= sr >> 8;
                           cnt <= cnt - LEN_BITS'(1);
                        end
                     end else begin
                        state <= ST_DROP;
                        o_err <= 1'b1;
                     end
                  end
               end
               ST_DROP: begin
                  // Discard until the terminator, then start a fresh token.
                  if (is_term) begin
                     state <= ST_FILL;
                     sr    <= '0;
                     cnt   <= '0;
                  end
               end
               default: state <= ST_FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shop_cmd_packer.sv
// Self-checking bench for shop_cmd_packer: directed literal checks plus a randomized
// stream compared every cycle against a token-queue model.
module tb_shop_cmd_packer;

   localparam int unsigned WORD_CHARS = 3;
   localparam int unsigned WORD_BITS  = 24;
`ifdef SHOP_CMD_PACKER_BACKSPACE_EN
   localparam bit BS_EN = 1'b1;
`else
   localparam bit BS_EN = 1'b0;
`endif

   logic                 i_clk = 1'b0;
   logic                 i_reset = 1'b1;
   logic                 i_c_vld = 1'b0;
   logic [7:0]           i_c = 8'h00;
   logic                 o_rdy;
   logic [WORD_BITS-1:0] o_a;
   logic                 o_err;
   logic [1:0]           o_len;

   int total = 0;
   int bad   = 0;

   shop_cmd_packer dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_c_vld (i_c_vld),
      .i_c     (i_c),
      .o_rdy   (o_rdy),
      .o_a     (o_a),
      .o_err   (o_err),
      .o_len   (o_len)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the current token is a queue of characters; a word is its base-256 value.
   logic [7:0]  tok[$];
   bit          dropping = 1'b0;
   bit          model_rst = 1'b1;
   bit          exp_rdy = 1'b0;
   bit          exp_err = 1'b0;
   logic [23:0] exp_a = '0;
   logic [1:0]  exp_len = '0;

   function automatic logic [23:0] pack_tok();
      logic [31:0] v = 0;
      foreach (tok[i]) v = v * 256 + 32'(tok[i]);
      return v[23:0];
   endfunction

   always @(posedge i_clk) begin
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      if (i_reset) begin
         model_rst = 1'b1;
         tok.delete();
         dropping = 1'b0;
         exp_a = '0;
         exp_len = '0;
      end else begin
         model_rst = 1'b0;
         if (i_c_vld) begin
            if (i_c == 8'h0A) begin
               if (!dropping && tok.size() > 0) begin
                  exp_rdy = 1'b1;
                  exp_a   = pack_tok();
                  exp_len = 2'(tok.size());
               end
               tok.delete();
               dropping = 1'b0;
            end else if (dropping || i_c == 8'h0D) begin
               // nothing happens
            end else if (i_c >= 8'h20 && i_c <= 8'h7E) begin
               if (tok.size() == WORD_CHARS) begin
                  dropping = 1'b1;
                  exp_err  = 1'b1;
               end else begin
                  tok.push_back(i_c);
               end
            end else if (BS_EN && (i_c == 8'h08 || i_c == 8'h7F)) begin
               if (tok.size() > 0) void'(tok.pop_back());
            end else begin
               dropping = 1'b1;
               exp_err  = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge i_clk) begin
      if (!model_rst) begin
         chk("cyc_rdy", 32'(o_rdy), 32'(exp_rdy));
         chk("cyc_err", 32'(o_err), 32'(exp_err));
         chk("cyc_a",   32'(o_a),   32'(exp_a));
         chk("cyc_len", 32'(o_len), 32'(exp_len));
      end
   end

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         i_c_vld = 1'b1;
         i_c     = s[i];
         @(negedge i_clk);
      end
      i_c_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      i_c_vld = 1'b0;
      for (int i = 0; i < n; i++) @(negedge i_clk);
   endtask

   function automatic logic [7:0] rand_char();
      case ($urandom_range(0, 19))
         0, 1, 2, 3, 4, 5, 6, 7: return 8'(8'h41 + $urandom_range(0, 25));
         8, 9, 10:               return 8'h0A;
         11:                     return 8'h0D;
         12:                     return ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
         13:                     return ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31))
                                                                    : 8'($urandom_range(128, 255));
         default:                return 8'($urandom_range(32, 126));
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_rdy", 32'(o_rdy), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_a",   32'(o_a),   32'd0);
      chk("rst_len", 32'(o_len), 32'd0);
      i_reset = 1'b0;
      idle(2);

      send_str("Adm\n");
      chk("adm_rdy", 32'(o_rdy), 32'd1);
      chk("adm_a",   32'(o_a),   32'h41646D);
      chk("adm_len", 32'(o_len), 32'd3);
      idle(1);
      chk("adm_rdy_low", 32'(o_rdy), 32'd0);

      send_str("Bu\015\n");
      chk("bu_a",   32'(o_a),   32'h004275);
      chk("bu_len", 32'(o_len), 32'd2);

      send_str("Logo");
      chk("logo_err", 32'(o_err), 32'd1);
      chk("logo_rdy", 32'(o_rdy), 32'd0);
      send_str("\n");
      chk("logo_lf_rdy", 32'(o_rdy), 32'd0);
      send_str("Buy\n");
      chk("buy_a", 32'(o_a), 32'h427579);

      send_str("\n\n");
      chk("empty_rdy", 32'(o_rdy), 32'd0);
      chk("empty_a",   32'(o_a),   32'h427579);

      send_str("A\001");
      chk("illegal_err", 32'(o_err), 32'd1);
      send_str("B\n");
      chk("illegal_rdy", 32'(o_rdy), 32'd0);
      chk("illegal_err2", 32'(o_err), 32'd0);
      send_str("X\n");
      chk("x_a",   32'(o_a),   32'h000058);
      chk("x_len", 32'(o_len), 32'd1);

      send_str("A\nB\n");
      chk("b2b_a", 32'(o_a), 32'h000042);

      send_str("Ad");
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      chk("midrst_a", 32'(o_a), 32'd0);
      send_str("\n");
      chk("midrst_rdy", 32'(o_rdy), 32'd0);
      chk("midrst_a2",  32'(o_a),   32'd0);
      send_str("Adm\n");
      chk("midrst_adm", 32'(o_a), 32'h41646D);

      if (BS_EN) begin
         send_str("Adx\010m\n");
         chk("bs_rdy", 32'(o_rdy), 32'd1);
         chk("bs_a",   32'(o_a),   32'h41646D);
      end else begin
         send_str("Adx\010");
         chk("bs_err", 32'(o_err), 32'd1);
         send_str("m\n");
         chk("bs_rdy", 32'(o_rdy), 32'd0);
      end
      idle(2);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            i_c_vld = 1'b0;
            i_reset = 1'b1;
            @(negedge i_clk);
            i_reset = 1'b0;
         end else begin
            i_c_vld = ($urandom_range(0, 3) != 0);
            i_c     = rand_char();
            @(negedge i_clk);
         end
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
